counter: RTL and testbench
==========================

COUNTER -- requirements
Module: counter

Interface
REQ-001 Parameter WIDTH, default 32: counter width in bits, legal range 2..64.
REQ-002 Parameter RESET_VALUE, default 0: value loaded while rst is high, truncated to WIDTH bits.
REQ-003 Parameter STEP, default 1: increment added per count event, legal range 1..2^WIDTH-1.
REQ-004 Parameter MODULUS, default 0: 0 = natural 2^WIDTH wrap; nonzero = count range 0..MODULUS-1.
REQ-005 Parameter PRESCALE, default 1: number of clk cycles per count event, legal range 1..65535.
REQ-006 clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 counter_out  output  WIDTH  current count, driven directly from a register.
REQ-009 wrap_out  output  1  one-cycle wrap pulse; present only when COUNTER_WRAP_OUT_EN is defined.
REQ-010 No other ports exist; an instance connecting only clk, rst and counter_out is complete.

Function
REQ-011 A prescale counter of ceil(log2(PRESCALE)) bits, minimum 1 bit, runs 0..PRESCALE-1 and wraps to 0; a count event occurs on the edge at which it wraps.
REQ-012 PRESCALE=1 makes every non-reset rising edge a count event, with no prescale register.
REQ-013 On a count event with MODULUS=0: counter_out <= (counter_out + STEP) mod 2^WIDTH.
REQ-014 On a count event with MODULUS!=0: sum = counter_out + STEP computed at WIDTH+1 bits; if sum >= MODULUS, counter_out <= sum - MODULUS, else counter_out <= sum.
REQ-015 MODULUS!=0 requires STEP < MODULUS, MODULUS <= 2^WIDTH and RESET_VALUE < MODULUS; elaboration shall fail otherwise.
REQ-016 Between count events counter_out holds its value.
REQ-017 A wrap condition is a count event on which the mod-2^WIDTH carry or the MODULUS subtraction occurs.
REQ-018 Latency: counter_out shows the new value one clk edge after rst is sampled low, or after a prescale wrap; there is no combinational path from rst to counter_out.
REQ-019 Output always lies in range: counter_out < MODULUS whenever MODULUS != 0.

Reset
REQ-020 While rst is sampled high: counter_out <= RESET_VALUE, prescale counter <= 0, wrap_out <= 0.
REQ-021 Reset takes priority over a count event on the same edge, including reset asserted mid-count or mid-prescale.
REQ-022 The first edge with rst low after reset is a count event when PRESCALE=1 (counter_out becomes RESET_VALUE+STEP), else the first prescale step.
REQ-023 State before the first reset is undefined; no initial values are relied upon.

Configuration
REQ-024 Macro COUNTER_WRAP_OUT_EN defined: wrap_out port and register exist; wrap_out is registered high for exactly the one cycle after the edge on which the wrap condition occurred.
REQ-025 Macro COUNTER_WRAP_OUT_EN undefined: no wrap_out port or logic; all other behaviour is identical.

Verification
REQ-026 Default parameters, rst high for 2 edges, then low for 100 edges -> counter_out is 0 during reset, then 1,2,...,100 on successive edges.
REQ-027 WIDTH=4, rst released, 17 edges -> counter_out sequence 1..15,0,1; with COUNTER_WRAP_OUT_EN, wrap_out is high only in the cycle counter_out=0.
REQ-028 MODULUS=10, STEP=3, RESET_VALUE=0 -> counter_out sequence 3,6,9,2,5,8,1.
REQ-029 PRESCALE=4 -> counter_out increments every 4th edge: holds 0 for 3 edges, then 1; holds for 3 edges, then 2.
REQ-030 rst pulsed high for 1 edge while counter_out=57 -> counter_out = RESET_VALUE on that edge; counting restarts from RESET_VALUE+STEP on the next edge.

Source files
------------

// File: rtl/counter.sv
// Parameterised up-counter with optional prescaler and modulus wrap.
// Define COUNTER_WRAP_OUT_EN to add the registered one-cycle wrap_out pulse.
module counter #(
  parameter int unsigned      WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [WIDTH-1:0] STEP        = WIDTH'(1),
  parameter logic [WIDTH:0]   MODULUS     = '0,
  parameter int unsigned      PRESCALE    = 1
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] counter_out
`ifdef COUNTER_WRAP_OUT_EN
  ,
  output logic             wrap_out
`endif
);

  localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  // Reject illegal configurations at elaboration
  if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
    $error("counter: WIDTH must be in 2..64");
  end
  if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_prescale
    $error("counter: PRESCALE must be in 1..65535");
  end
  if (STEP == '0) begin : g_bad_step
    $error("counter: STEP must be nonzero");
  end
  if (MODULUS != '0) begin : g_mod_check
    if ({1'b0, STEP} >= MODULUS) begin : g_bad_mod_step
      $error("counter: STEP must be below MODULUS");
    end
    if (MODULUS > {1'b1, {WIDTH{1'b0}}}) begin : g_bad_mod_range
      $error("counter: MODULUS must not exceed 2^WIDTH");
    end
    if ({1'b0, RESET_VALUE} >= MODULUS) begin : g_bad_mod_reset
      $error("counter: RESET_VALUE must be below MODULUS");
    end
  end

  logic             tick_c;
  logic [WIDTH-1:0] next_c;

  if (PRESCALE == 1) begin : g_no_ps
    assign tick_c = 1'b1;
  end else begin : g_ps
    logic [PS_W-1:0] ps_q;

    assign tick_c = (ps_q == PS_W'(PRESCALE - 1));

    always_ff @(posedge clk) begin
      if (rst || tick_c) begin
        ps_q <= '0;
      end else begin
        ps_q <= ps_q + PS_W'(1);
      end
    end
  end

  if (MODULUS == '0) begin : g_nat
    assign next_c = counter_out + STEP;
  end else begin : g_mod
    logic [WIDTH:0] sum_c;

    assign sum_c = {1'b0, counter_out} + {1'b0, STEP};

    always_comb begin
      next_c = sum_c[WIDTH-1:0];
      if (sum_c >= MODULUS) begin
        next_c = WIDTH'(sum_c - MODULUS);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      counter_out <= RESET_VALUE;
    end else if (tick_c) begin
      counter_out <= next_c;
    end
  end

`ifdef COUNTER_WRAP_OUT_EN
  // STEP is below the wrap range, so a carry or modulus subtraction is
  // exactly the case where the next value drops below the current one.
  logic wrap_c;

  assign wrap_c = (next_c < counter_out);

  always_ff @(posedge clk) begin
    if (rst) begin
      wrap_out <= 1'b0;
    end else begin
      wrap_out <= tick_c && wrap_c;
    end
  end
`endif

endmodule

// File: tb/tb_counter.sv
// Directed bench for counter: several parameterisations share clk and rst.
// Checks wrap_out as well when COUNTER_WRAP_OUT_EN is defined.
module tb_counter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  logic [31:0] c0;
  logic [3:0]  c1;
  logic [3:0]  c2;
  logic [31:0] c3;
  logic [7:0]  c4;
  logic [3:0]  c5;
`ifdef COUNTER_WRAP_OUT_EN
  logic w0, w1, w2, w3, w4, w5;
`endif

  int unsigned mod10_seq [7] = '{3, 6, 9, 2, 5, 8, 1};

  counter u0 (
    .clk(clk), .rst(rst), .counter_out(c0)
`ifdef COUNTER_WRAP_OUT_EN
    , .wrap_out(w0)
`endif
  );

  counter #(.WIDTH(4)) u1 (
    .clk(clk), .rst(rst), .counter_out(c1)
`ifdef COUNTER_WRAP_OUT_EN
    , .wrap_out(w1)
`endif
  );

  counter #(.WIDTH(4), .STEP(4'd3), .MODULUS(5'd10)) u2 (
    .clk(clk), .rst(rst), .counter_out(c2)
`ifdef COUNTER_WRAP_OUT_EN
    , .wrap_out(w2)
`endif
  );

  counter #(.PRESCALE(4)) u3 (
    .clk(clk), .rst(rst), .counter_out(c3)
`ifdef COUNTER_WRAP_OUT_EN
    , .wrap_out(w3)
`endif
  );

  counter #(.WIDTH(8), .RESET_VALUE(8'd7), .STEP(8'd2)) u4 (
    .clk(clk), .rst(rst), .counter_out(c4)
`ifdef COUNTER_WRAP_OUT_EN
    , .wrap_out(w4)
`endif
  );

  counter #(.WIDTH(4), .RESET_VALUE(4'd15), .STEP(4'd5), .MODULUS(5'd16)) u5 (
    .clk(clk), .rst(rst), .counter_out(c5)
`ifdef COUNTER_WRAP_OUT_EN
    , .wrap_out(w5)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle before sampling
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned e5;
    int unsigned s5;
    bit          wrap5;

    rst = 1'b1;
    step();
    step();
    check("rst_u0", 64'(c0), 64'd0);
    check("rst_u1", 64'(c1), 64'd0);
    check("rst_u2", 64'(c2), 64'd0);
    check("rst_u3", 64'(c3), 64'd0);
    check("rst_u4", 64'(c4), 64'd7);
    check("rst_u5", 64'(c5), 64'd15);
`ifdef COUNTER_WRAP_OUT_EN
    check("rst_w1", 64'(w1), 64'd0);
    check("rst_w2", 64'(w2), 64'd0);
`endif

    rst = 1'b0;
    e5 = 15;
    for (int i = 1; i <= 100; i++) begin
      step();
      s5 = e5 + 5;
      wrap5 = (s5 >= 16);
      e5 = wrap5 ? s5 - 16 : s5;
      check($sformatf("u0_%0d", i), 64'(c0), 64'(i));
      check($sformatf("u1_%0d", i), 64'(c1), 64'(i % 16));
      if (i <= 7) begin
        check($sformatf("u2_seq_%0d", i), 64'(c2), 64'(mod10_seq[i-1]));
      end else begin
        check($sformatf("u2_%0d", i), 64'(c2), 64'((3 * i) % 10));
      end
      check($sformatf("u3_%0d", i), 64'(c3), 64'(i / 4));
      check($sformatf("u4_%0d", i), 64'(c4), 64'((7 + 2 * i) % 256));
      check($sformatf("u5_%0d", i), 64'(c5), 64'(e5));
`ifdef COUNTER_WRAP_OUT_EN
      check($sformatf("w0_%0d", i), 64'(w0), 64'd0);
      check($sformatf("w1_%0d", i), 64'(w1), 64'(i % 16 == 0));
      check($sformatf("w2_%0d", i), 64'(w2), 64'(((3 * (i - 1)) % 10) + 3 >= 10));
      check($sformatf("w3_%0d", i), 64'(w3), 64'd0);
      check($sformatf("w4_%0d", i), 64'(w4), 64'((7 + 2 * i) % 256 < 2));
      check($sformatf("w5_%0d", i), 64'(w5), 64'(wrap5));
`endif
    end

    // Restart, run to 57, then a one-edge reset pulse mid-count and mid-prescale
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 1; i <= 57; i++) begin
      step();
    end
    check("pre_u0", 64'(c0), 64'd57);
    check("pre_u1", 64'(c1), 64'd9);
    check("pre_u3", 64'(c3), 64'd14);
    rst = 1'b1;
    step();
    check("pulse_u0", 64'(c0), 64'd0);
    check("pulse_u3", 64'(c3), 64'd0);
    check("pulse_u4", 64'(c4), 64'd7);
    check("pulse_u5", 64'(c5), 64'd15);
`ifdef COUNTER_WRAP_OUT_EN
    check("pulse_w1", 64'(w1), 64'd0);
`endif
    rst = 1'b0;
    step();
    check("restart_u0", 64'(c0), 64'd1);
    check("restart_u2", 64'(c2), 64'd3);
    check("restart_u4", 64'(c4), 64'd9);
    check("restart_u5", 64'(c5), 64'd4);
    check("restart_u3_e1", 64'(c3), 64'd0);
    step();
    check("restart_u3_e2", 64'(c3), 64'd0);
    step();
    check("restart_u3_e3", 64'(c3), 64'd0);
    step();
    check("restart_u3_e4", 64'(c3), 64'd1);
    check("restart_u0_e4", 64'(c0), 64'd4);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
